// File: rtl/serial_alu.sv
// serial_alu
// ----------
// Bit-serial ALU: a single 1-bit slice is sequenced over a WIDTH-bit operand
// word, LSB first, one bit per clock. The carry chain is kept in a flop
// between bits. A word-level request is taken with a start/busy/done
// handshake and the full result is returned with carry and overflow flags.
//
// Opcode {add_sub, op}:
//   000 AND, 001 OR, 010 ADD, 110 SUB (a + ~b + 1), 111 SLT (signed a < b)
//   011/100/101 are illegal: they run for the normal time and return zeros.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   request pulse, taken when not in RUN
//   add_sub  in   opcode MSB
//   op       in   opcode low bits [1:0]
//   a, b     in   operands [WIDTH-1:0], captured on an accepted start
//   busy     out  high while bits are being processed
//   done     out  one-cycle pulse, result/flags valid
//   result   out  [WIDTH-1:0] result, held until the next accepted start
//   cout     out  final carry (ADD/SUB only)
//   ovf      out  signed overflow (ADD/SUB only)

module serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             add_sub,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [2:0] OPC_AND = 3'b000;
  localparam logic [2:0] OPC_OR  = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_SUB = 3'b110;
  localparam logic [2:0] OPC_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [2:0]       opc_q,    opc_d;
  logic             carry_q,  carry_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] shift_q,  shift_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;

  logic             is_arith;
  logic             invert_b;
  logic             bit_a;
  logic             bit_b;
  logic             sum_bit;
  logic             carry_out;
  logic             slice_bit;
  logic             ovf_bit;

  // The 1-bit slice. SUB and SLT feed the inverted B bit; the +1 comes from
  // the carry flop being preloaded with 1 when the request is accepted.
  always_comb begin
    is_arith  = (opc_q == OPC_ADD) || (opc_q == OPC_SUB) || (opc_q == OPC_SLT);
    invert_b  = (opc_q == OPC_SUB) || (opc_q == OPC_SLT);
    bit_a     = a_q[0];
    bit_b     = b_q[0] ^ invert_b;
    sum_bit   = bit_a ^ bit_b ^ carry_q;
    carry_out = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));
    // On the MSB step carry_q is the carry into the MSB.
    ovf_bit   = carry_q ^ carry_out;

    unique case (opc_q)
      OPC_AND:                  slice_bit = a_q[0] & b_q[0];
      OPC_OR:                   slice_bit = a_q[0] | b_q[0];
      OPC_ADD, OPC_SUB, OPC_SLT: slice_bit = sum_bit;
      default:                  slice_bit = 1'b0;
    endcase
  end

  // Next-state and datapath update. IDLE and DONE both accept a start, so a
  // request in the DONE cycle chains directly into the next operation.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    opc_d    = opc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d  = S_RUN;
          a_d      = a;
          b_d      = b;
          opc_d    = {add_sub, op};
          carry_d  = add_sub && op[1];
          cnt_d    = '0;
          shift_d  = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
        end
      end

      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        shift_d = {slice_bit, shift_q[WIDTH-1:1]};
        carry_d = is_arith ? carry_out : 1'b0;
        if (cnt_q == LAST_BIT) begin
          // MSB step: publish the final word and flags.
          state_d = S_DONE;
          unique case (opc_q)
            OPC_ADD, OPC_SUB: begin
              result_d = shift_d;
              cout_d   = carry_out;
              ovf_d    = ovf_bit;
            end
            OPC_SLT: begin
              // Signed less-than is the sign of a-b corrected by overflow.
              result_d = {{(WIDTH-1){1'b0}}, sum_bit ^ ovf_bit};
              cout_d   = 1'b0;
              ovf_d    = 1'b0;
            end
            default: begin
              result_d = shift_d;
              cout_d   = 1'b0;
              ovf_d    = 1'b0;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      opc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      shift_q  <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opc_q    <= opc_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu
// -------------
// Directed-vector bench for serial_alu (WIDTH=8). Each scenario task drives
// its own stimulus and compares the outputs against hand-computed values.

module tb_serial_alu;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             add_sub;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  int checks;
  int errors;

  serial_alu #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .add_sub (add_sub),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cout    (cout),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request from a post-edge sampling point and follow it to done.
  // Samples are taken 1 time unit after each rising edge; the first sample
  // is the cycle right after the accepting edge. lat is the sample index at
  // which done was seen (-1 if it never came).
  task automatic run_op(input logic [2:0] opc, input logic [7:0] av,
                        input logic [7:0] bv, output logic [7:0] r,
                        output logic c, output logic o, output int lat,
                        output int busy_cnt, output logic both,
                        output logic [7:0] r0);
    {add_sub, op} = opc;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    r0       = result;
    lat      = -1;
    busy_cnt = 0;
    both     = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (busy && done) both = 1'b1;
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    r = result;
    c = cout;
    o = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; add_sub = 1'b0; op = 2'b10; a = 8'h11; b = 8'h22;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, result, cout, ovf} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_state: busy=%b done=%b result=%h cout=%b ovf=%b, required all 0",
               busy, done, result, cout, ovf);
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_add();
    logic [7:0] r, r0; logic c, o, both; int lat, bc;
    run_op(3'b010, 8'h7F, 8'h01, r, c, o, lat, bc, both, r0);
    checks++;
    if (lat !== 9) begin errors++; $display("[TB] FAIL add_latency: got %0d required 9", lat); end
    checks++;
    if (bc !== 8) begin errors++; $display("[TB] FAIL add_busy_cycles: got %0d required 8", bc); end
    checks++;
    if (both !== 1'b0) begin errors++; $display("[TB] FAIL add_busy_done_overlap: got %b required 0", both); end
    checks++;
    if ({r, c, o} !== {8'h80, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL add_7f_01: result=%h cout=%b ovf=%b, required 80 0 1", r, c, o);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, result} !== {1'b0, 8'h80}) begin
      errors++;
      $display("[TB] FAIL add_done_pulse_hold: done=%b result=%h, required 0 80", done, result);
    end
  endtask

  task automatic test_sub();
    logic [7:0] r, r0; logic c, o, both; int lat, bc;
    run_op(3'b110, 8'h05, 8'h07, r, c, o, lat, bc, both, r0);
    checks++;
    if ({r, c, o} !== {8'hFE, 1'b0, 1'b0} || lat !== 9) begin
      errors++;
      $display("[TB] FAIL sub_05_07: result=%h cout=%b ovf=%b lat=%0d, required fe 0 0 9", r, c, o, lat);
    end
    run_op(3'b110, 8'h80, 8'h01, r, c, o, lat, bc, both, r0);
    checks++;
    if ({r, c, o} !== {8'h7F, 1'b1, 1'b1} || lat !== 9) begin
      errors++;
      $display("[TB] FAIL sub_80_01: result=%h cout=%b ovf=%b lat=%0d, required 7f 1 1 9", r, c, o, lat);
    end
  endtask

  task automatic test_slt();
    logic [7:0] r, r0; logic c, o, both; int lat, bc;
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] vr [3];
    va = '{8'hFF, 8'h01, 8'h80};
    vb = '{8'h01, 8'hFF, 8'h7F};
    vr = '{8'h01, 8'h00, 8'h01};
    for (int i = 0; i < 3; i++) begin
      run_op(3'b111, va[i], vb[i], r, c, o, lat, bc, both, r0);
      checks++;
      if ({r, c, o} !== {vr[i], 1'b0, 1'b0} || lat !== 9) begin
        errors++;
        $display("[TB] FAIL slt_%h_%h: result=%h cout=%b ovf=%b lat=%0d, required %h 0 0 9",
                 va[i], vb[i], r, c, o, lat, vr[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [7:0] r, r0; logic c, o, both; int lat, bc;
    run_op(3'b000, 8'hF0, 8'h3C, r, c, o, lat, bc, both, r0);
    checks++;
    if ({r, c, o} !== {8'h30, 1'b0, 1'b0} || lat !== 9) begin
      errors++;
      $display("[TB] FAIL and_f0_3c: result=%h cout=%b ovf=%b lat=%0d, required 30 0 0 9", r, c, o, lat);
    end
    run_op(3'b001, 8'hF0, 8'h3C, r, c, o, lat, bc, both, r0);
    checks++;
    if ({r, c, o} !== {8'hFC, 1'b0, 1'b0} || lat !== 9) begin
      errors++;
      $display("[TB] FAIL or_f0_3c: result=%h cout=%b ovf=%b lat=%0d, required fc 0 0 9", r, c, o, lat);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] r, r0; logic c, o, both; int lat, bc;
    run_op(3'b101, 8'hFF, 8'hFF, r, c, o, lat, bc, both, r0);
    checks++;
    if ({r, c, o} !== {8'h00, 1'b0, 1'b0} || lat !== 9) begin
      errors++;
      $display("[TB] FAIL illegal_101: result=%h cout=%b ovf=%b lat=%0d, required 00 0 0 9", r, c, o, lat);
    end
  endtask

  task automatic test_start_in_run();
    int lat;
    {add_sub, op} = 3'b010; a = 8'h10; b = 8'h20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Third RUN cycle: a competing request with different operands.
    {add_sub, op} = 3'b001; a = 8'h0F; b = 8'h0F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 4; i <= 30; i++) begin
      if (done) begin lat = i; break; end
      @(posedge clk); #1;
    end
    checks++;
    if ({result, cout, ovf} !== {8'h30, 1'b0, 1'b0} || lat !== 9) begin
      errors++;
      $display("[TB] FAIL start_in_run: result=%h cout=%b ovf=%b lat=%0d, required 30 0 0 9",
               result, cout, ovf, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r, r0; logic c, o, both; int lat, bc;
    run_op(3'b010, 8'h33, 8'h44, r, c, o, lat, bc, both, r0);
    checks++;
    if (r !== 8'h77 || lat !== 9) begin
      errors++;
      $display("[TB] FAIL b2b_first: result=%h lat=%0d, required 77 9", r, lat);
    end
    // Issued from the DONE cycle sample point.
    run_op(3'b110, 8'h10, 8'h20, r, c, o, lat, bc, both, r0);
    checks++;
    if (r0 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL b2b_clear_on_start: result=%h required 00", r0);
    end
    checks++;
    if ({r, c, o} !== {8'hF0, 1'b0, 1'b0} || lat !== 9) begin
      errors++;
      $display("[TB] FAIL b2b_second: result=%h cout=%b ovf=%b lat=%0d, required f0 0 0 9", r, c, o, lat);
    end
  endtask

  task automatic test_reset_in_run();
    logic [7:0] r, r0; logic c, o, both; int lat, bc;
    logic saw_done;
    {add_sub, op} = 3'b010; a = 8'h7F; b = 8'h7F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, done, result, cout, ovf} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_in_run: busy=%b done=%b result=%h cout=%b ovf=%b, required all 0",
               busy, done, result, cout, ovf);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_run_no_done: activity=%b required 0", saw_done);
    end
    run_op(3'b010, 8'h01, 8'h01, r, c, o, lat, bc, both, r0);
    checks++;
    if ({r, c, o} !== {8'h02, 1'b0, 1'b0} || lat !== 9) begin
      errors++;
      $display("[TB] FAIL add_after_reset: result=%h cout=%b ovf=%b lat=%0d, required 02 0 0 9", r, c, o, lat);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    add_sub = 1'b0;
    op      = 2'b00;
    a       = '0;
    b       = '0;
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_illegal();
    test_start_in_run();
    test_back_to_back();
    test_reset_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_alu.md
# serial_alu

Bit-serial WIDTH-bit ALU datapath that sequences one 1-bit ALU slice over a full operand word, LSB first, one bit per clock. It sits directly upstream of the 1-bit slice and keeps the carry chain in a flip-flop between bits. It accepts a word-level request with a start/busy/done handshake and returns the WIDTH-bit result plus carry and overflow flags. It targets small-area designs where one shared slice replaces a ripple array.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits (≥2)

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only when not busy
- add_sub  input  1  operation select, MSB of opcode
- op  input  2  operation select, low bits of opcode
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse, result/flags valid
- result  output  WIDTH  operation result, held until next accepted start
- cout  output  1  final carry out (ADD/SUB only)
- ovf  output  1  signed overflow (ADD/SUB only)

## Operation

- Opcode {add_sub,op}: 000 AND, 001 OR, 010 ADD, 110 SUB (a + ~b + 1), 111 SLT (signed a < b). Codes 011/100/101 are illegal: they run normally and return result=0, cout=0, ovf=0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 → capture a, b, opcode into shift registers. Load carry flop with 1 for SUB/SLT, else 0. Clear bit counter and go to RUN.
  - RUN: each cycle, compute bit i from a[i], b[i] (inverted for SUB/SLT) and the carry flop. Update the carry flop and shift the sum bit into the result register from the MSB side. On the WIDTH-th bit → DONE.
  - DONE: done=1 for this cycle only; result/cout/ovf are final. Next state is IDLE. If start=1 in DONE, it is accepted exactly as in IDLE and the next state is RUN.
- start while in RUN is ignored (not queued).
- Flags:
  - ovf = carry-into-MSB XOR carry-out-of-MSB for ADD/SUB; 0 otherwise.
  - cout = final carry for ADD/SUB; 0 for AND/OR/SLT/illegal. For SUB, cout=1 means no borrow.
- SLT: internally a subtract. Final result = {WIDTH-1 zeros, sum_msb XOR ovf_sub}; cout=0, ovf=0.
- AND/OR: carry flop held at 0, carry chain unused.
- Outputs change only on the edge entering DONE, on reset, or on an accepted start. On an accepted start, result/cout/ovf are cleared to 0.
- Counter width: clog2(WIDTH); no wrap-around beyond WIDTH-1.

## Timing

- Reset (rst=1 at an edge): state IDLE, busy=0, done=0, result=0, cout=0, ovf=0, counter=0, carry=0. This overrides start in the same cycle.
- Reset during RUN aborts the operation: no done pulse, outputs are 0.
- start accepted at edge E0 → busy=1 from E0 through E(WIDTH). Bits are processed on edges E1..E(WIDTH). done=1 in the cycle after E(WIDTH), with busy=0 in that cycle. Latency from start to done = WIDTH+1 cycles.
- Throughput: back-to-back start in the DONE cycle gives one result every WIDTH+1 cycles.
- busy and done are never high simultaneously.

## Test plan

- WIDTH=8, ADD a=0x7F b=0x01 → done exactly 9 cycles after start edge; result=0x80, cout=0, ovf=1; busy high for 8 cycles.
- SUB a=0x05 b=0x07 → result=0xFE, cout=0, ovf=0. SUB a=0x80 b=0x01 → result=0x7F, cout=1, ovf=1.
- SLT a=0xFF b=0x01 → result=0x01. SLT a=0x01 b=0xFF → result=0x00. SLT a=0x80 b=0x7F → result=0x01. All three with cout=0, ovf=0.
- AND a=0xF0 b=0x3C → result=0x30. OR same operands → 0xFC. Illegal opcode 101 → result=0x00; cout=0, ovf=0 in every case.
- start pulsed again at cycle 3 of RUN with different operands → ignored; the original result is delivered. start asserted in the DONE cycle → second operation accepted, its done arrives 9 cycles later.
- rst asserted during the 4th RUN cycle → next cycle busy=0, result=0, and no done pulse appears. After reset, a fresh ADD 0x01+0x01 → 0x02.
